lc3_control: RTL and testbench

LC3_CONTROL -- requirements
Module: lc3_control

---
 rtl/lc3_pkg.sv | 38 +++
 rtl/lc3_control_if.sv | 33 +++
 rtl/lc3_decode.sv | 40 ++++
 rtl/lc3_control.sv | 146 ++++++++++++++
 tb/tb_lc3_control.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 control unit: FSM states,
// opcodes, ALU operation and PC-source selects.
package lc3_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_IFETCH_WAIT,
    S_LOAD_IR,
    S_DECODE,
    S_EXEC_ALU,
    S_BR,
    S_JMP,
    S_ADDR,
    S_LD_WAIT,
    S_LD_WB,
    S_ST_MDR,
    S_ST_WAIT,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] ALUK_PASS = 2'b00;
  localparam logic [1:0] ALUK_ADD  = 2'b01;
  localparam logic [1:0] ALUK_AND  = 2'b10;
  localparam logic [1:0] ALUK_NOT  = 2'b11;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_OFF9 = 2'b01;
  localparam logic [1:0] PCMUX_BASE = 2'b10;

endpackage

// File: rtl/lc3_control_if.sv
// Control-unit bundle: instruction/condition inputs, memory handshake and
// every datapath strobe. master = controller, slave = datapath/memory side.
interface lc3_control_if;
  // Memory handshake: mem_en stays high for the whole access; the access
  // completes in the cycle mem_ready is high while mem_en is high, and
  // mem_ready is ignored whenever mem_en is low.
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_ready;

  logic        ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc;
  logic        gate_pc, gate_alu, gate_mdr, gate_marmux;
  logic [1:0]  alu_k;
  logic [2:0]  sr1, sr2, dr;
  logic [1:0]  pc_mux;
  logic        mem_en, mem_we;
  logic        halted;
  logic [15:0] instr_count;

  modport master (
    input  ir, nzp, mem_ready,
    output ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
    output gate_pc, gate_alu, gate_mdr, gate_marmux,
    output alu_k, sr1, sr2, dr, pc_mux, mem_en, mem_we, halted, instr_count
  );

  modport slave (
    output ir, nzp, mem_ready,
    input  ld_pc, ld_ir, ld_mar, ld_mdr, ld_reg, ld_cc,
    input  gate_pc, gate_alu, gate_mdr, gate_marmux,
    input  alu_k, sr1, sr2, dr, pc_mux, mem_en, mem_we, halted, instr_count
  );
endinterface

// File: rtl/lc3_decode.sv
// Combinational opcode and field decode: dispatch target out of DECODE,
// ALU operation, register fields and branch-taken evaluation.
module lc3_decode
  import lc3_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [2:0]  nzp_i,
  output state_e      dispatch_o,
  output logic [1:0]  alu_k_o,
  output logic [2:0]  dr_o,
  output logic [2:0]  sr1_o,
  output logic [2:0]  sr2_o,
  output logic        br_taken_o,
  output logic        is_store_o
);
  logic [3:0] opcode;
  logic       unused_bits;

  assign opcode      = ir_i[15:12];
  assign dr_o        = ir_i[11:9];
  assign sr1_o       = ir_i[8:6];
  assign sr2_o       = ir_i[2:0];
  assign br_taken_o  = |(ir_i[11:9] & nzp_i);
  assign is_store_o  = (opcode == OP_ST);
  assign unused_bits = ^ir_i[5:3];

  always_comb begin
    dispatch_o = S_HALT;
    alu_k_o    = ALUK_PASS;
    case (opcode)
      OP_ADD:       begin dispatch_o = S_EXEC_ALU; alu_k_o = ALUK_ADD; end
      OP_AND:       begin dispatch_o = S_EXEC_ALU; alu_k_o = ALUK_AND; end
      OP_NOT:       begin dispatch_o = S_EXEC_ALU; alu_k_o = ALUK_NOT; end
      OP_BR:        dispatch_o = S_BR;
      OP_JMP:       dispatch_o = S_JMP;
      OP_LD, OP_ST: dispatch_o = S_ADDR;
      default:      dispatch_o = S_HALT;
    endcase
  end
endmodule

// File: rtl/lc3_control.sv
// LC-3 multicycle Moore control FSM with retired-instruction counter.
// Strobes are gated by rst_n so reset silences them immediately.
module lc3_control
  import lc3_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  lc3_control_if.master       bus,
  output state_e              state_o
);
  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        retire;

  state_e      dispatch;
  logic [1:0]  dec_alu_k;
  logic [2:0]  dec_dr, dec_sr1, dec_sr2;
  logic        br_taken, is_store;

  lc3_decode u_decode (
    .ir_i       (bus.ir),
    .nzp_i      (bus.nzp),
    .dispatch_o (dispatch),
    .alu_k_o    (dec_alu_k),
    .dr_o       (dec_dr),
    .sr1_o      (dec_sr1),
    .sr2_o      (dec_sr2),
    .br_taken_o (br_taken),
    .is_store_o (is_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.ld_pc       = 1'b0;
    bus.ld_ir       = 1'b0;
    bus.ld_mar      = 1'b0;
    bus.ld_mdr      = 1'b0;
    bus.ld_reg      = 1'b0;
    bus.ld_cc       = 1'b0;
    bus.gate_pc     = 1'b0;
    bus.gate_alu    = 1'b0;
    bus.gate_mdr    = 1'b0;
    bus.gate_marmux = 1'b0;
    bus.alu_k       = ALUK_PASS;
    bus.sr1         = 3'd0;
    bus.sr2         = 3'd0;
    bus.dr          = 3'd0;
    bus.pc_mux      = PCMUX_INC;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.halted      = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.gate_pc = 1'b1;
          bus.ld_mar  = 1'b1;
          bus.ld_pc   = 1'b1;
          state_d     = S_IFETCH_WAIT;
        end
        S_IFETCH_WAIT, S_LD_WAIT: begin
          bus.mem_en = 1'b1;
          if (bus.mem_ready) begin
            bus.ld_mdr = 1'b1;
            state_d    = (state_q == S_IFETCH_WAIT) ? S_LOAD_IR : S_LD_WB;
          end
        end
        S_LOAD_IR: begin
          bus.gate_mdr = 1'b1;
          bus.ld_ir    = 1'b1;
          state_d      = S_DECODE;
        end
        S_DECODE: state_d = dispatch;
        S_EXEC_ALU: begin
          bus.gate_alu = 1'b1;
          bus.ld_reg   = 1'b1;
          bus.ld_cc    = 1'b1;
          bus.alu_k    = dec_alu_k;
          bus.dr       = dec_dr;
          bus.sr1      = dec_sr1;
          bus.sr2      = dec_sr2;
          state_d      = S_FETCH;
        end
        S_BR: begin
          if (br_taken) begin
            bus.ld_pc  = 1'b1;
            bus.pc_mux = PCMUX_OFF9;
          end
          state_d = S_FETCH;
        end
        S_JMP: begin
          bus.ld_pc  = 1'b1;
          bus.pc_mux = PCMUX_BASE;
          bus.sr1    = dec_sr1;
          state_d    = S_FETCH;
        end
        S_ADDR: begin
          bus.gate_marmux = 1'b1;
          bus.ld_mar      = 1'b1;
          state_d         = is_store ? S_ST_MDR : S_LD_WAIT;
        end
        S_LD_WB: begin
          bus.gate_mdr = 1'b1;
          bus.ld_reg   = 1'b1;
          bus.ld_cc    = 1'b1;
          bus.dr       = dec_dr;
          state_d      = S_FETCH;
        end
        // Store data is the register named in the DR field, passed through the ALU.
        S_ST_MDR: begin
          bus.gate_alu = 1'b1;
          bus.alu_k    = ALUK_PASS;
          bus.sr1      = dec_dr;
          bus.ld_mdr   = 1'b1;
          state_d      = S_ST_WAIT;
        end
        S_ST_WAIT: begin
          bus.mem_en = 1'b1;
          bus.mem_we = 1'b1;
          if (bus.mem_ready) state_d = S_FETCH;
        end
        S_HALT:  bus.halted = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_EXEC_ALU, S_BR, S_JMP, S_LD_WB, S_ST_WAIT});
    count_d = retire ? count_q + 16'd1 : count_q;
  end

  assign bus.instr_count = count_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_lc3_control.sv
// Bench for lc3_control: an instruction-level model expands each instruction
// into its expected per-cycle strobe trace, compared cycle by cycle.
module tb_lc3_control;
  import lc3_pkg::*;

  localparam int W = 42;

  localparam logic [9:0] B_LPC  = 10'b1000000000;
  localparam logic [9:0] B_LIR  = 10'b0100000000;
  localparam logic [9:0] B_LMAR = 10'b0010000000;
  localparam logic [9:0] B_LMDR = 10'b0001000000;
  localparam logic [9:0] B_LREG = 10'b0000100000;
  localparam logic [9:0] B_LCC  = 10'b0000010000;
  localparam logic [9:0] B_GPC  = 10'b0000001000;
  localparam logic [9:0] B_GALU = 10'b0000000100;
  localparam logic [9:0] B_GMDR = 10'b0000000010;
  localparam logic [9:0] B_GMAR = 10'b0000000001;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  lc3_control_if bus ();

  lc3_control dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [15:0]  model_cnt;
  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] got_vec();
    return {bus.ld_pc, bus.ld_ir, bus.ld_mar, bus.ld_mdr, bus.ld_reg, bus.ld_cc,
            bus.gate_pc, bus.gate_alu, bus.gate_mdr, bus.gate_marmux,
            bus.alu_k, bus.sr1, bus.sr2, bus.dr, bus.pc_mux,
            bus.mem_en, bus.mem_we, bus.halted, bus.instr_count};
  endfunction

  function automatic logic [W-1:0] vec(input logic [9:0] s, input logic [1:0] ak,
                                       input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] d, input logic [1:0] pm,
                                       input logic en, input logic we, input logic h);
    return {s, ak, a, b, d, pm, en, we, h, model_cnt};
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic [W-1:0] v);
    rdy_q.push_back(r);
    exp_q.push_back(v);
  endtask

  // A memory access: k cycles without mem_ready, then one completing cycle.
  task automatic mem_access(input int k, input logic [9:0] done_s, input logic we);
    for (int i = 0; i < k; i++) push(1'b0, vec(10'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, we, 1'b0));
    push(1'b1, vec(done_s, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, we, 1'b0));
  endtask

  // Instruction-level reference: expected strobe trace for one instruction.
  task automatic model_instr(input logic [15:0] ir, input logic [2:0] nzp,
                             input int kf, input int km);
    logic [3:0] op;
    logic [1:0] ak;
    logic       taken;
    op = ir[15:12];
    push(noise(), vec(B_GPC | B_LMAR | B_LPC, 2'd0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0));
    mem_access(kf, B_LMDR, 1'b0);
    push(noise(), vec(B_GMDR | B_LIR, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    push(noise(), vec(10'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    case (op)
      4'h1, 4'h5, 4'h9: begin
        ak = (op == 4'h1) ? 2'b01 : (op == 4'h5) ? 2'b10 : 2'b11;
        push(noise(), vec(B_GALU | B_LREG | B_LCC, ak, ir[8:6], ir[2:0], ir[11:9], 2'd0, 1'b0, 1'b0, 1'b0));
        model_cnt++;
      end
      4'h0: begin
        taken = (ir[11:9] & nzp) != 3'd0;
        push(noise(), vec(taken ? B_LPC : 10'd0, 2'd0, 3'd0, 3'd0, 3'd0, taken ? 2'b01 : 2'b00,
                          1'b0, 1'b0, 1'b0));
        model_cnt++;
      end
      4'hC: begin
        push(noise(), vec(B_LPC, 2'd0, ir[8:6], 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b0));
        model_cnt++;
      end
      4'h2: begin
        push(noise(), vec(B_GMAR | B_LMAR, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        mem_access(km, B_LMDR, 1'b0);
        push(noise(), vec(B_GMDR | B_LREG | B_LCC, 2'd0, 3'd0, 3'd0, ir[11:9], 2'd0, 1'b0, 1'b0, 1'b0));
        model_cnt++;
      end
      4'h3: begin
        push(noise(), vec(B_GMAR | B_LMAR, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        push(noise(), vec(B_GALU | B_LMDR, 2'b00, ir[11:9], 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        mem_access(km, 10'd0, 1'b1);
        model_cnt++;
      end
      default: begin
        for (int i = 0; i < 10; i++)
          push(noise(), vec(10'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1));
      end
    endcase
  endtask

  // Driver: entered and left at posedge+1; compares on the falling edge.
  task automatic drain(input string tag);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      chk(tag, got_vec(), e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] ir, input logic [2:0] nzp,
                     input int kf, input int km);
    bus.ir  = ir;
    bus.nzp = nzp;
    model_instr(ir, nzp, kf, km);
    drain(tag);
  endtask

  logic [3:0]  ops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hC};
  logic [31:0] r;

  initial begin
    rst_n         = 1'b0;
    bus.ir        = 16'h0000;
    bus.nzp       = 3'b000;
    bus.mem_ready = 1'b1;
    model_cnt     = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out", got_vec(), '0);
    chk("reset_state", W'(dbg_state), W'(S_FETCH));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run("add", 16'h1283, 3'b000, 0, 0);
    run("and", 16'h5A42, 3'b100, 1, 0);
    run("not", 16'h967F, 3'b001, 0, 0);
    run("brz_taken", 16'h0402, 3'b010, 0, 0);
    run("brz_not", 16'h0402, 3'b001, 2, 0);
    run("ld", 16'h2205, 3'b000, 0, 3);
    run("st", 16'h3405, 3'b000, 1, 2);
    run("st_fast", 16'h3E00, 3'b000, 0, 0);
    run("jmp", 16'hC1C0, 3'b000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      run("rand", {ops[$urandom_range(0, 6)], r[11:0]}, r[14:12],
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run("halt", 16'hD000, 3'b000, 0, 0);

    rst_n = 1'b0;
    #1 chk("halt_rst_now", got_vec(), '0);
    @(negedge clk);
    chk("halt_rst_held", got_vec(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = 16'd0;
    run("post_halt", 16'h1283, 3'b000, 1, 0);
    run("post_halt2", 16'h0E01, 3'b100, 0, 0);

    // Reset in the middle of an instruction-fetch wait.
    bus.ir = 16'h1283;
    push(1'b0, vec(B_GPC | B_LMAR | B_LPC, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    push(1'b0, vec(10'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0));
    drain("pre_mid_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_now", got_vec(), '0);
    @(posedge clk);
    #1 bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_held", got_vec(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_cnt = 16'd0;
    run("post_mid_rst", 16'h1283, 3'b000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
